// File: rtl/weight_comp_scheduler.sv
// ============================================================================
// Module   : weight_comp_scheduler
// Purpose  : Packs serial vector elements into chunks for a weight-computation
//            cell chain, and collects the chain results into a credit-managed
//            FIFO. Optional stall counter under WEIGHT_COMP_SCHED_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_comp_scheduler #(
  parameter int DATA_WIDTH    = 32,
  parameter int INPUT_AMOUNT  = 4,
  parameter int WEIGHT_AMOUNT = 8,
  parameter int CHAIN_LENGTH  = 2,
  parameter int RESULT_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic [DATA_WIDTH-1:0]              cell_index,
  output logic [INPUT_AMOUNT*DATA_WIDTH-1:0] cell_value,
  output logic [DATA_WIDTH:0]                cell_result,
  output logic                               cell_enable,
  input  logic [DATA_WIDTH:0]                chain_result,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               busy,
  output logic                               overflow
`ifdef WEIGHT_COMP_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]                        stall_cycles
`endif
);

  localparam int C_NUM_CHUNKS = WEIGHT_AMOUNT / INPUT_AMOUNT;
  localparam int C_LANE_W     = (INPUT_AMOUNT > 1) ? $clog2(INPUT_AMOUNT) : 1;
  localparam int C_CHUNK_W    = (C_NUM_CHUNKS > 1) ? $clog2(C_NUM_CHUNKS) : 1;
  localparam int C_PTR_W      = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int C_CNT_W      = $clog2(RESULT_DEPTH + 1);

  localparam logic [C_LANE_W-1:0]  C_LAST_LANE  = C_LANE_W'(INPUT_AMOUNT - 1);
  localparam logic [C_CHUNK_W-1:0] C_LAST_CHUNK = C_CHUNK_W'(C_NUM_CHUNKS - 1);
  localparam logic [C_PTR_W-1:0]   C_PTR_LAST   = C_PTR_W'(RESULT_DEPTH - 1);
  localparam logic [C_CNT_W-1:0]   C_CREDITS    = C_CNT_W'(CHAIN_LENGTH);
  localparam logic [C_CNT_W:0]     C_USED_LIMIT = (C_CNT_W + 1)'(RESULT_DEPTH - CHAIN_LENGTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_ISSUE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [C_LANE_W-1:0]               r_lane;
  logic [C_CHUNK_W-1:0]              r_chunk;
  logic [INPUT_AMOUNT*DATA_WIDTH-1:0] r_cell_value;
  logic [DATA_WIDTH-1:0]             r_cell_index;
  logic                              r_cell_enable;
  logic [C_CNT_W-1:0]                r_outstanding;
  logic [C_CNT_W-1:0]                r_count;
  logic [C_PTR_W-1:0]                r_wr_ptr;
  logic [C_PTR_W-1:0]                r_rd_ptr;
  logic                              r_overflow;
  logic [DATA_WIDTH-1:0]             r_mem [RESULT_DEPTH];

  logic             w_in_ready;
  logic             w_reserve;
  logic             w_accept;
  logic             w_credit_ok;
  logic             w_result_vld;
  logic             w_capture;
  logic             w_pop;
  logic [C_CNT_W:0] w_used;

  // Free slots are judged on registered occupancy plus credits already promised.
  assign w_used       = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit_ok  = (w_used <= C_USED_LIMIT);
  assign w_result_vld = chain_result[DATA_WIDTH];
  assign w_capture    = w_result_vld && (r_outstanding != '0);
  assign w_pop        = (r_count != '0) && out_ready;
  assign w_accept     = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_reserve    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = w_credit_ok;
        if (in_valid && w_credit_ok) begin
          w_reserve    = 1'b1;
          w_state_next = (r_lane == C_LAST_LANE) ? S_ISSUE : S_GATHER;
        end
      end
      S_GATHER: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = (r_lane == C_LAST_LANE) ? S_ISSUE : S_GATHER;
        end
      end
      S_ISSUE: begin
        w_state_next = (r_chunk == C_LAST_CHUNK) ? S_IDLE : S_GATHER;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Chunk assembly and issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane        <= '0;
      r_chunk       <= '0;
      r_cell_value  <= '0;
      r_cell_index  <= '0;
      r_cell_enable <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cell_value[r_lane*DATA_WIDTH +: DATA_WIDTH] <= in_data;
        r_lane <= (r_lane == C_LAST_LANE) ? '0 : r_lane + 1'b1;
      end
      if (r_state == S_ISSUE) begin
        r_chunk <= (r_chunk == C_LAST_CHUNK) ? '0 : r_chunk + 1'b1;
      end
      r_cell_enable <= (w_state_next == S_ISSUE);
      if (w_state_next == S_ISSUE) begin
        r_cell_index <= DATA_WIDTH'(r_chunk) * DATA_WIDTH'(INPUT_AMOUNT);
      end
    end
  end

  // Credit accounting, FIFO pointers and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_outstanding <= r_outstanding + (w_reserve ? C_CREDITS : '0)
                                     - (w_capture ? C_CNT_W'(1) : '0);
      r_count <= r_count + (w_capture ? C_CNT_W'(1) : '0)
                         - (w_pop ? C_CNT_W'(1) : '0);
      if (w_capture) begin
        r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_result_vld && (r_outstanding == '0)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= chain_result[DATA_WIDTH-1:0];
    end
  end

`ifdef WEIGHT_COMP_SCHED_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (in_valid && !w_in_ready && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign in_ready    = w_in_ready && rst_n;
  assign cell_index  = r_cell_index;
  assign cell_value  = r_cell_value;
  assign cell_result = '0;
  assign cell_enable = r_cell_enable;
  assign out_valid   = (r_count != '0);
  assign out_data    = out_valid ? r_mem[r_rd_ptr] : '0;
  assign busy        = (r_state != S_IDLE) || (r_outstanding != '0);
  assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: doc/weight_comp_scheduler.md
# weight_comp_scheduler

Sequencer that feeds a chain of weight-computation cells. It packs a serial stream of input-vector elements into INPUT_AMOUNT-wide chunks and issues each chunk to the first cell with its element index. It collects valid results from the last cell into a result FIFO. A credit scheme guarantees that every result a vector will produce has a FIFO slot before that vector is accepted.

## Interface
- DATA_WIDTH, 32: element and result data width.
- INPUT_AMOUNT, 4: elements per chunk (lanes of cell_value).
- WEIGHT_AMOUNT, 8: elements per vector. Must be a multiple of INPUT_AMOUNT.
- CHAIN_LENGTH, 2: results produced per vector (number of cells in the chain).
- RESULT_DEPTH, 4: result FIFO entries. Must be at least CHAIN_LENGTH.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  scheduler accepts the element this cycle.
- in_data  in  DATA_WIDTH  input element.
- cell_index  out  DATA_WIDTH  index of lane 0 of the issued chunk.
- cell_value  out  INPUT_AMOUNT*DATA_WIDTH  chunk; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- cell_result  out  DATA_WIDTH+1  partial result injected into the chain; always {1'b0, 0}.
- cell_enable  out  1  chunk valid; one-cycle pulse.
- chain_result  in  DATA_WIDTH+1  result from the last cell; MSB is the valid bit.
- out_valid  out  1  result FIFO is not empty.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_WIDTH  head of the result FIFO.
- busy  out  1  a vector is partially accepted, or results are still outstanding.
- overflow  out  1  sticky error flag; cleared only by reset.

## Operation
- States: IDLE, GATHER, ISSUE.
- IDLE:
  - in_ready = 1 only when free ≥ CHAIN_LENGTH, where free = RESULT_DEPTH − fifo_count − outstanding.
  - Accepting the first element reserves CHAIN_LENGTH credits (outstanding += CHAIN_LENGTH), writes lane 0, and moves to GATHER. If INPUT_AMOUNT = 1 it moves straight to ISSUE.
- GATHER:
  - in_ready = 1; each accepted element fills the next lane.
  - Accepting the INPUT_AMOUNT-th element of the chunk moves to ISSUE.
- ISSUE:
  - Lasts exactly one cycle with in_ready = 0.
  - Drives cell_enable = 1 and cell_index = chunk_number*INPUT_AMOUNT (0, 4, 8, … for the default INPUT_AMOUNT).
  - Next state is GATHER if chunks remain in the vector. After chunk WEIGHT_AMOUNT/INPUT_AMOUNT − 1, chunk_number returns to 0 and the next state is IDLE.
- Result capture:
  - Each cycle where chain_result[DATA_WIDTH] = 1 and outstanding > 0: push chain_result[DATA_WIDTH-1:0] into the FIFO and decrement outstanding.
  - A valid chain_result with outstanding = 0 is dropped and sets overflow.
- FIFO: pop when out_valid && out_ready. Push and pop in the same cycle are both performed. Pointers wrap modulo RESULT_DEPTH.
- Simultaneous credit reservation and result capture: outstanding changes by CHAIN_LENGTH − 1. The free check uses values registered at the start of the cycle.
- busy = (state ≠ IDLE) || (outstanding ≠ 0).

## Timing
- Reset values: in_ready 0 while rst_n is low, then follows the IDLE rule; cell_index 0; cell_value 0; cell_result 0; cell_enable 0; out_valid 0; out_data 0; busy 0; overflow 0; state IDLE; FIFO empty; outstanding 0.
- All outputs are registered except in_ready, out_valid, out_data and busy, which are decoded from registers.
- Issue latency: cell_enable rises the cycle after the edge that accepts the last element of a chunk.
- Peak throughput: one chunk per INPUT_AMOUNT+1 cycles.
- Result latency: a result is visible on out_data the cycle after it is captured.
- Reset mid-vector: the partial chunk and its reserved credits are discarded. The next vector starts at cell_index 0. Results from the chain that arrive after reset set overflow.

## Configuration
- WEIGHT_COMP_SCHED_STALL_CNT_EN:
  - Defined: adds output stall_cycles [31:0], reset to 0. It increments (saturating at 2^32−1) on every cycle with in_valid = 1 and in_ready = 0.
  - Undefined: the port and the counter do not exist.

## Test plan
(All scenarios use default parameters.)
- Reset: hold rst_n = 0 for 3 cycles -> every output is at its reset value; in_ready = 1 the cycle after release.
- Feed 1..8 back-to-back:
  - First pulse: cell_enable with cell_index 0 and cell_value {4,3,2,1} (lane 3..0).
  - Second pulse: cell_enable with cell_index 4 and cell_value {8,7,6,5}.
  - Exactly 2 pulses in total; busy = 1.
- Results: drive chain_result {1,13}, then {1,14} -> out_data 13 then 14 with out_ready = 1; busy falls after the second capture.
- Credits: out_ready = 0 and two complete vectors, each answered with 2 results -> the FIFO holds 4 and in_ready = 0 for a third vector. One pop -> free is still 1, so in_ready stays 0. A second pop -> in_ready = 1.
- Stray result: chain_result {1,99} while outstanding = 0 -> no push; overflow = 1 and stays 1 until reset.
- Reset mid-GATHER after 3 elements, then feed 8 elements -> first pulse has cell_index 0 and holds the new elements only.
